// File: rtl/noc_pe_interface.sv
// PE-side network interface: packs host words into mesh flits through an injection FIFO
// and captures switch-ejected flits into a drop-counting ejection FIFO.
module noc_pe_interface #(
    parameter int unsigned X           = 2,
    parameter int unsigned Y           = 2,
    parameter int unsigned data_width  = 32,
    parameter int unsigned x_size      = 1,
    parameter int unsigned y_size      = 1,
    parameter int unsigned total_width = x_size + y_size + data_width,
    parameter int unsigned INJ_DEPTH   = 4,
    parameter int unsigned EJ_DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [data_width-1:0]  s_data,
    input  logic [x_size-1:0]      s_dest_x,
    input  logic [y_size-1:0]      s_dest_y,
    output logic                   o_valid_sw,
    input  logic                   i_ready_sw,
    output logic [total_width-1:0] o_data_sw,
    input  logic                   i_valid_sw,
    input  logic [total_width-1:0] i_data_sw,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [data_width-1:0]  m_data,
    output logic                   overflow,
    output logic                   bad_dest,
    output logic [15:0]            drop_count
);

    localparam int unsigned INJ_AW = $clog2(INJ_DEPTH);
    localparam int unsigned EJ_AW  = $clog2(EJ_DEPTH);
    localparam int unsigned CW     = x_size + y_size;

    localparam logic [INJ_AW:0] INJ_ONE = (INJ_AW + 1)'(1);
    localparam logic [EJ_AW:0]  EJ_ONE  = (EJ_AW + 1)'(1);

    // ---------------- injection path ----------------
    logic [INJ_AW:0]        inj_wr;
    logic [INJ_AW:0]        inj_rd;
    logic [total_width-1:0] inj_mem [INJ_DEPTH];
    logic                   inj_full;
    logic                   inj_empty;
    logic                   dest_ok;
    logic                   inj_accept;
    logic                   inj_push;
    logic                   inj_pop;

    assign inj_full   = (inj_wr[INJ_AW] != inj_rd[INJ_AW]) &&
                        (inj_wr[INJ_AW-1:0] == inj_rd[INJ_AW-1:0]);
    assign inj_empty  = (inj_wr == inj_rd);
    assign dest_ok    = (32'(s_dest_x) < X) && (32'(s_dest_y) < Y);
    assign inj_accept = s_valid & ~inj_full;
    assign inj_push   = inj_accept & dest_ok;
    assign inj_pop    = ~inj_empty & i_ready_sw;

    assign s_ready    = ~inj_full;
    assign o_valid_sw = ~inj_empty;
    assign o_data_sw  = inj_mem[inj_rd[INJ_AW-1:0]];

    // Pointers and the illegal-destination flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inj_wr   <= '0;
            inj_rd   <= '0;
            bad_dest <= 1'b0;
        end else begin
            if (inj_push) inj_wr <= inj_wr + INJ_ONE;
            if (inj_pop)  inj_rd <= inj_rd + INJ_ONE;
            if (inj_accept && !dest_ok) bad_dest <= 1'b1;
        end
    end

    // Storage is left unreset; it is only observable behind o_valid_sw
    always_ff @(posedge clk) begin
        if (inj_push) inj_mem[inj_wr[INJ_AW-1:0]] <= total_width'({s_data, s_dest_y, s_dest_x});
    end

    // ---------------- ejection path ----------------
    logic [EJ_AW:0]        ej_wr;
    logic [EJ_AW:0]        ej_rd;
    logic [data_width-1:0] ej_mem [EJ_DEPTH];
    logic                  ej_full;
    logic                  ej_empty;
    logic                  ej_pop;
    logic                  ej_push;
    logic                  ej_drop;
    logic                  unused_coord;

    assign ej_full  = (ej_wr[EJ_AW] != ej_rd[EJ_AW]) &&
                      (ej_wr[EJ_AW-1:0] == ej_rd[EJ_AW-1:0]);
    assign ej_empty = (ej_wr == ej_rd);
    assign ej_pop   = ~ej_empty & m_ready;
    // A full FIFO still takes a flit when the host frees a slot in the same cycle
    assign ej_push  = i_valid_sw & (~ej_full | ej_pop);
    assign ej_drop  = i_valid_sw & ~ej_push;

    assign m_valid      = ~ej_empty;
    assign m_data       = ej_mem[ej_rd[EJ_AW-1:0]];
    assign unused_coord = ^i_data_sw[CW-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ej_wr      <= '0;
            ej_rd      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (ej_push) ej_wr <= ej_wr + EJ_ONE;
            if (ej_pop)  ej_rd <= ej_rd + EJ_ONE;
            if (ej_drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ej_push) ej_mem[ej_wr[EJ_AW-1:0]] <= i_data_sw[total_width-1:CW];
    end

endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed bench for noc_pe_interface: injection ordering, ejection overflow, bad destinations, reset.
module tb_noc_pe_interface;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic [0:0]  s_dest_x, s_dest_y;
    logic        o_valid_sw, i_ready_sw;
    logic [33:0] o_data_sw;
    logic        i_valid_sw;
    logic [33:0] i_data_sw;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic        overflow, bad_dest;
    logic [15:0] drop_count;

    // Second instance with a single mesh column so dest_x=1 is illegal
    logic        s_valid1, s_ready1;
    logic [31:0] s_data1;
    logic [0:0]  s_dest_x1, s_dest_y1;
    logic        o_valid_sw1;
    logic        i_ready_sw1 = 1'b0;
    logic [33:0] o_data_sw1;
    logic        i_valid_sw1 = 1'b0;
    logic [33:0] i_data_sw1 = '0;
    logic        m_valid1;
    logic        m_ready1 = 1'b0;
    logic [31:0] m_data1;
    logic        overflow1, bad_dest1;
    logic [15:0] drop_count1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    noc_pe_interface u_dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_dest_x(s_dest_x), .s_dest_y(s_dest_y),
        .o_valid_sw(o_valid_sw), .i_ready_sw(i_ready_sw), .o_data_sw(o_data_sw),
        .i_valid_sw(i_valid_sw), .i_data_sw(i_data_sw),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .overflow(overflow), .bad_dest(bad_dest), .drop_count(drop_count)
    );

    noc_pe_interface #(.X(1)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .s_dest_x(s_dest_x1), .s_dest_y(s_dest_y1),
        .o_valid_sw(o_valid_sw1), .i_ready_sw(i_ready_sw1), .o_data_sw(o_data_sw1),
        .i_valid_sw(i_valid_sw1), .i_data_sw(i_data_sw1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .overflow(overflow1), .bad_dest(bad_dest1), .drop_count(drop_count1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs are driven and outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [33:0] q[$];
    logic [31:0] eq[$];
    logic        do_push, do_pop;

    initial begin
        rstn = 1'b0;
        s_valid = 0; s_data = '0; s_dest_x = '0; s_dest_y = '0;
        i_ready_sw = 0; i_valid_sw = 0; i_data_sw = '0; m_ready = 0;
        s_valid1 = 0; s_data1 = '0; s_dest_x1 = '0; s_dest_y1 = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_o_valid", 64'(o_valid_sw), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_flags", 64'({overflow, bad_dest}), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        rstn = 1'b1;
        tick();

        // Fill injection FIFO with the switch stalled
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 32'hA0 + 32'(i); s_dest_x = 1'b1; s_dest_y = 1'b0;
            check("fill_s_ready", 64'(s_ready), 64'd1);
            tick();
            check("fill_o_valid", 64'(o_valid_sw), 64'd1);
            q.push_back({32'hA0 + 32'(i), 1'b0, 1'b1});
        end
        s_valid = 0;
        check("full_s_ready", 64'(s_ready), 64'd0);
        check("full_head", 64'(o_data_sw), 64'({32'hA0, 1'b0, 1'b1}));
        check("no_bad_dest", 64'(bad_dest), 64'd0);

        // Drain while pushing 0xB0; then drain to empty
        i_ready_sw = 1;
        for (int c = 0; c < 12; c++) begin
            s_valid = (c < 4); s_data = 32'hB0; s_dest_x = 1'b1; s_dest_y = 1'b0;
            check("inj_s_ready", 64'(s_ready), 64'(q.size() < 4));
            check("inj_o_valid", 64'(o_valid_sw), 64'(q.size() > 0));
            if (q.size() > 0) check("inj_data", 64'(o_data_sw), 64'(q[0]));
            do_push = s_valid && (q.size() < 4);
            do_pop  = (q.size() > 0);
            tick();
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({32'hB0, 1'b0, 1'b1});
        end
        s_valid = 0; i_ready_sw = 0;
        check("inj_drained", 64'(o_valid_sw), 64'd0);

        // Ejection burst of 10 with host stalled: 8 kept, 2 dropped
        for (int i = 1; i <= 10; i++) begin
            i_valid_sw = 1; i_data_sw = {32'(i), 1'b1, 1'b0};
            tick();
            if (i == 1) check("ej_latency", 64'(m_valid), 64'd1);
        end
        i_valid_sw = 0;
        check("ej_overflow", 64'(overflow), 64'd1);
        check("ej_drop_count", 64'(drop_count), 64'd2);
        check("ej_head", 64'(m_data), 64'd1);

        // Full FIFO: simultaneous pop and write of 0x55 is not a drop
        m_ready = 1; i_valid_sw = 1; i_data_sw = {32'h55, 1'b0, 1'b1};
        check("ej_pop1", 64'(m_data), 64'd1);
        tick();
        i_valid_sw = 0;
        check("ej_no_drop", 64'(drop_count), 64'd2);
        for (int i = 2; i <= 8; i++) eq.push_back(32'(i));
        eq.push_back(32'h55);
        while (eq.size() > 0) begin
            check("ej_valid", 64'(m_valid), 64'd1);
            check("ej_data", 64'(m_data), 64'(eq.pop_front()));
            tick();
        end
        m_ready = 0;
        check("ej_drained", 64'(m_valid), 64'd0);

        // Illegal destination on the single-column instance, then a legal one
        s_valid1 = 1; s_data1 = 32'hDD; s_dest_x1 = 1'b1; s_dest_y1 = 1'b0;
        check("bad_s_ready", 64'(s_ready1), 64'd1);
        tick();
        check("bad_dest_set", 64'(bad_dest1), 64'd1);
        check("bad_no_valid", 64'(o_valid_sw1), 64'd0);
        s_data1 = 32'hEE; s_dest_x1 = 1'b0; s_dest_y1 = 1'b1;
        tick();
        s_valid1 = 0;
        check("legal_valid", 64'(o_valid_sw1), 64'd1);
        check("legal_data", 64'(o_data_sw1), 64'({32'hEE, 1'b1, 1'b0}));
        check("bad_sticky", 64'(bad_dest1), 64'd1);

        // Half-fill both FIFOs, then assert reset between clock edges
        for (int i = 0; i < 4; i++) begin
            s_valid = (i < 2); s_data = 32'hC0; s_dest_x = 1'b0; s_dest_y = 1'b0;
            i_valid_sw = 1; i_data_sw = {32'h60 + 32'(i), 2'b00};
            tick();
        end
        s_valid = 0; i_valid_sw = 0;
        check("mid_o_valid", 64'(o_valid_sw), 64'd1);
        check("mid_m_valid", 64'(m_valid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_o_valid", 64'(o_valid_sw), 64'd0);
        check("arst_m_valid", 64'(m_valid), 64'd0);
        check("arst_s_ready", 64'(s_ready), 64'd1);
        check("arst_drop_count", 64'(drop_count), 64'd0);
        check("arst_flags", 64'({overflow, bad_dest1}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Traffic resumes after reset
        s_valid = 1; s_data = 32'hC1; s_dest_x = 1'b0; s_dest_y = 1'b1;
        i_valid_sw = 1; i_data_sw = {32'h77, 2'b11};
        tick();
        s_valid = 0; i_valid_sw = 0;
        check("post_o_data", 64'(o_data_sw), 64'({32'hC1, 1'b1, 1'b0}));
        check("post_m_data", 64'(m_data), 64'h77);
        check("post_m_valid", 64'(m_valid), 64'd1);
        i_ready_sw = 1; m_ready = 1;
        tick();
        check("post_empty", 64'({o_valid_sw, m_valid}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
